// File: rtl/pio_poll_master.sv
// Polls one register of an input PIO over Avalon-MM and emits a valid/ready
// sample each time the low DATA_W bits change (and once after reset).
module pio_poll_master #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned TARGET_ADDR  = 0,
  parameter int unsigned POLL_DIV     = 50000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  input  logic              overflow_clr
);

  localparam int unsigned CNT_W = $clog2(POLL_DIV);
  localparam int unsigned LAT_W = 2;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_DIV - 1);
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, READ, LAT} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   tick_cnt;
  logic [LAT_W-1:0]   lat_cnt, lat_cnt_nxt;
  logic               pending;
  logic               first;
  logic [DATA_W-1:0]  last;
  logic               tick_c;
  logic               start_c;
  logic               capture_c;
  logic [DATA_W-1:0]  sample_c;
  logic               changed_c;
  logic               slot_free_c;
  logic               unused_rdata_c;

  assign tick_c         = enable && (tick_cnt == '0);
  assign sample_c       = avm_readdata[DATA_W-1:0];
  assign changed_c      = first || (sample_c != last);
  assign slot_free_c    = !out_valid || out_ready;
  assign unused_rdata_c = ^avm_readdata;

  // Read sequencing: wait for a poll request, issue the read, wait out latency.
  always_comb begin
    state_nxt   = state;
    lat_cnt_nxt = lat_cnt;
    start_c     = 1'b0;
    capture_c   = 1'b0;
    case (state)
      IDLE: begin
        if (pending && enable) begin
          state_nxt = READ;
          start_c   = 1'b1;
        end
      end
      READ: begin
        if (!avm_waitrequest) begin
          state_nxt   = LAT;
          lat_cnt_nxt = LAT_INIT;
        end
      end
      LAT: begin
        if (lat_cnt != '0) begin
          lat_cnt_nxt = lat_cnt - LAT_W'(1);
        end else begin
          capture_c = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      lat_cnt     <= '0;
      tick_cnt    <= CNT_MAX;
      pending     <= 1'b0;
      first       <= 1'b1;
      last        <= '0;
      avm_read    <= 1'b0;
      avm_address <= 2'(TARGET_ADDR);
      out_data    <= '0;
      out_valid   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_nxt;
      lat_cnt     <= lat_cnt_nxt;
      avm_read    <= (state_nxt == READ);
      avm_address <= 2'(TARGET_ADDR);

      if (enable) begin
        tick_cnt <= tick_c ? CNT_MAX : tick_cnt - CNT_W'(1);
      end
      // A new tick outranks the clear so a request is never lost.
      pending <= tick_c | (pending & ~start_c);

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (overflow_clr) begin
        overflow <= 1'b0;
      end

      // Later assignments win: a reload beats the handshake, a drop beats the clear.
      if (capture_c) begin
        last  <= sample_c;
        first <= 1'b0;
        if (changed_c) begin
          if (slot_free_c) begin
            out_data  <= sample_c;
            out_valid <= 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pio_poll_master.sv
// Randomized bench for pio_poll_master: a transaction-level reference predicts
// bus requests, stream beats and the sticky overflow flag every cycle.
module tb_pio_poll_master;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned TARGET_ADDR  = 2;
  localparam int unsigned POLL_DIV     = 4;
  localparam int unsigned READ_LATENCY = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [1:0]        avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              overflow;
  logic              overflow_clr;
  logic [7:0]        in_val;

  int n_cmp = 0;
  int n_bad = 0;
  int beats = 0;

  // Slave side: data presented READ_LATENCY cycles after acceptance, garbage otherwise.
  bit         s_hold = 1'b0;
  logic [7:0] s_data = '0;

  // Reference state, kept in terms of polls and transactions rather than states.
  int         m_timer;
  bit         m_pend;
  bit         m_busy;
  bit         m_req;
  int         m_wait_left;
  logic [7:0] m_smp;
  bit         m_first;
  logic [7:0] m_last;
  bit         m_valid;
  logic [7:0] m_data;
  bit         m_ovf;

  pio_poll_master #(
    .DATA_W(DATA_W), .TARGET_ADDR(TARGET_ADDR),
    .POLL_DIV(POLL_DIV), .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_timer     = POLL_DIV - 1;
    m_pend      = 1'b0;
    m_busy      = 1'b0;
    m_req       = 1'b0;
    m_wait_left = 0;
    m_smp       = '0;
    m_first     = 1'b1;
    m_last      = '0;
    m_valid     = 1'b0;
    m_data      = '0;
    m_ovf       = 1'b0;
  endtask

  // One clock edge of the reference, using the inputs held across that edge.
  task automatic model_step();
    bit tick, start, do_cap, free, changed;
    if (reset) begin
      model_reset();
      return;
    end
    tick   = enable && (m_timer == 0);
    start  = !m_busy && m_pend && enable;
    do_cap = 1'b0;
    if (m_busy && !m_req) begin
      m_wait_left--;
      if (m_wait_left == 0) begin
        do_cap = 1'b1;
        m_busy = 1'b0;
      end
    end else if (m_busy && m_req && !avm_waitrequest) begin
      m_req       = 1'b0;
      m_wait_left = READ_LATENCY;
      m_smp       = in_val;
    end
    free = !m_valid || out_ready;
    if (m_valid && out_ready) m_valid = 1'b0;
    if (overflow_clr) m_ovf = 1'b0;
    if (do_cap) begin
      changed = m_first || (m_smp != m_last);
      m_last  = m_smp;
      m_first = 1'b0;
      if (changed) begin
        if (free) begin
          m_data  = m_smp;
          m_valid = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
    if (start) begin
      m_busy = 1'b1;
      m_req  = 1'b1;
      m_pend = 1'b0;
    end
    if (tick) m_pend = 1'b1;
    if (enable) m_timer = tick ? POLL_DIV - 1 : m_timer - 1;
  endtask

  // Called at a falling edge after inputs for the next rising edge are set.
  task automatic cycle();
    avm_readdata = s_hold ? {24'($urandom), s_data} : 32'($urandom);
    s_hold = avm_read && !avm_waitrequest && !reset;
    s_data = in_val;
    if (out_valid && out_ready && !reset) beats++;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("avm_read", 32'(avm_read), 32'(m_req));
    check("avm_address", 32'(avm_address), 32'(TARGET_ADDR));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'(m_data));
    check("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_read(input string tag);
    for (int i = 0; i < 40 && !avm_read; i++) cycle();
    check(tag, 32'(avm_read), 32'd1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; avm_waitrequest = 1'b0; avm_readdata = '0;
    in_val = 8'h5A; out_ready = 1'b1; overflow_clr = 1'b0;
    model_reset();
    @(negedge clk);
    run(3);
    reset = 1'b0; enable = 1'b1;

    // Constant input: one beat only, across more than ten polls.
    run(48);
    check("beats_const", 32'(beats), 32'd1);

    // Single change between polls.
    in_val = 8'hA5;
    run(12);
    check("beats_change", 32'(beats), 32'd2);

    // Stalled read.
    in_val = 8'h3C;
    wait_read("read_seen_stall");
    avm_waitrequest = 1'b1;
    run(3);
    avm_waitrequest = 1'b0;
    run(10);

    // Blocked consumer: drop, clear, then clear pulses around further drops.
    out_ready = 1'b0;
    in_val = 8'h01;
    run(8);
    in_val = 8'h02;
    run(8);
    overflow_clr = 1'b1;
    run(1);
    overflow_clr = 1'b0;
    in_val = 8'h03;
    for (int i = 0; i < 8; i++) begin
      overflow_clr = 1'(i % 2);
      run(1);
    end
    overflow_clr = 1'b0;
    out_ready = 1'b1;
    run(8);

    // Enable dropped while the read is in its latency phase.
    in_val = 8'h77;
    wait_read("read_seen_lat");
    run(1);
    enable = 1'b0;
    run(10);
    enable = 1'b1;
    run(12);

    // Reset during a read; the post-reset poll re-emits the unchanged input.
    wait_read("read_seen_reset");
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    run(12);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      enable          = ($urandom % 8) != 0;
      avm_waitrequest = ($urandom % 3) == 0;
      out_ready       = ($urandom % 4) != 0;
      overflow_clr    = ($urandom % 10) == 0;
      reset           = ($urandom % 400) == 0;
      if (($urandom % 6) == 0)
        in_val = ($urandom % 2) ? 8'($urandom % 4) : 8'($urandom);
      run(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
